bram_stream_reader: RTL



---
 rtl/bram_stream_reader_if.sv | 26 ++
 rtl/bram_stream_reader_sync_stream_fifo.sv | 55 +++++
 rtl/bram_stream_reader.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/bram_stream_reader_if.sv
// Push/pop bus between the burst reader and its output buffer.
// The reader drives the master side and the buffer sits on the slave side.
interface bram_stream_reader_if #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             push;
  logic [WIDTH-1:0] pushData;
  logic             pop;
  logic [WIDTH-1:0] popData;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;

  modport master (
    output push, pushData, pop,
    input  popData, full, empty, count
  );

  modport slave (
    input  push, pushData, pop,
    output popData, full, empty, count
  );
endinterface

// File: rtl/bram_stream_reader_sync_stream_fifo.sv
// Small synchronous FIFO with a first-word-fall-through head.
// Occupancy is tracked by an explicit counter so that full and empty are direct compares.
module sync_stream_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  bram_stream_reader_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign bus.full    = (r_count == CW'(DEPTH));
  assign bus.empty   = (r_count == '0);
  assign bus.count   = r_count;
  assign bus.popData = r_mem[r_rdPtr];

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign w_doPop  = bus.pop && !bus.empty;
  assign w_doPush = bus.push && (!bus.full || w_doPop);

  always_ff @(posedge clk_in) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= bus.pushData;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/bram_stream_reader.sv
// Reads a burst of consecutive words from a block RAM and streams them out with valid/ready.
// Reads are throttled so that words in flight plus buffered words never exceed the buffer depth.
module bram_stream_reader #(
  parameter  int RAM_WIDTH    = 18,
  parameter  int RAM_DEPTH    = 1024,
  parameter  int READ_LATENCY = 2,
  parameter  int FIFO_DEPTH   = 4,
  localparam int AW           = $clog2(RAM_DEPTH)
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 start_in,
  input  logic [AW-1:0]        base_addr_in,
  input  logic [AW:0]          len_in,
  output logic                 busy_out,
  output logic                 done_out,
  output logic [AW-1:0]        ram_addr_out,
  output logic                 ram_en_out,
  output logic                 ram_regce_out,
  input  logic [RAM_WIDTH-1:0] ram_data_in,
  output logic [RAM_WIDTH-1:0] data_out,
  output logic                 valid_out,
  output logic                 last_out,
  input  logic                 ready_in
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  r_state;
  logic [AW-1:0]           r_addr;
  logic [AW:0]             r_len;
  logic [AW:0]             r_issued;
  logic                    r_done;
  logic [READ_LATENCY-1:0] r_tagValid;
  logic [READ_LATENCY-1:0] r_tagLast;

  logic [CW:0]             w_inflight;
  logic [CW:0]             w_pending;
  logic                    w_issue;
  logic                    w_lastIssue;
  logic                    w_valid;
  logic                    w_handshake;
  logic                    w_headLast;
  logic [RAM_WIDTH-1:0]    w_headData;

  bram_stream_reader_if #(.WIDTH(RAM_WIDTH + 1), .DEPTH(FIFO_DEPTH)) w_fifoBus ();

  sync_stream_fifo #(
    .WIDTH (RAM_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (w_fifoBus)
  );

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      w_inflight = w_inflight + (CW + 1)'(r_tagValid[i]);
    end
  end

  // Every issued read already owns a buffer slot, so the buffer can never overflow.
  assign w_pending   = w_inflight + (CW + 1)'(w_fifoBus.count);
  assign w_issue     = (r_state == RUN) && (r_issued < r_len) &&
                       (w_pending < (CW + 1)'(FIFO_DEPTH)) && !w_fifoBus.full;
  assign w_lastIssue = (r_issued == r_len - (AW + 1)'(1));

  assign w_fifoBus.push     = r_tagValid[READ_LATENCY-1];
  assign w_fifoBus.pushData = {r_tagLast[READ_LATENCY-1], ram_data_in};
  assign w_fifoBus.pop      = w_handshake;
  assign {w_headLast, w_headData} = w_fifoBus.popData;

  assign w_valid     = !w_fifoBus.empty;
  assign w_handshake = w_valid && ready_in;

  assign valid_out     = w_valid;
  assign data_out      = w_valid ? w_headData : '0;
  assign last_out      = w_valid && w_headLast;
  assign ram_en_out    = w_issue;
  assign ram_addr_out  = r_addr;
  assign ram_regce_out = 1'b1;
  assign busy_out      = (r_state == RUN);
  assign done_out      = r_done;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_len    <= '0;
      r_issued <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_in) begin
            if (len_in == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state  <= RUN;
              r_addr   <= base_addr_in;
              r_len    <= len_in;
              r_issued <= '0;
            end
          end
        end
        RUN: begin
          if (w_issue) begin
            r_addr   <= (r_addr == AW'(RAM_DEPTH - 1)) ? '0 : r_addr + AW'(1);
            r_issued <= r_issued + (AW + 1)'(1);
          end
          if (w_handshake && w_headLast) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The tag shift register mirrors the RAM latency so data is captured exactly when it lands.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_tagValid <= '0;
      r_tagLast  <= '0;
    end else begin
      r_tagValid[0] <= w_issue;
      r_tagLast[0]  <= w_issue && w_lastIssue;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_tagValid[i] <= r_tagValid[i-1];
        r_tagLast[i]  <= r_tagLast[i-1];
      end
    end
  end
endmodule
